// File: rtl/pulse_seq.sv
`timescale 1ns/1ps
// Machine-cycle pulse sequencer: READ_PHASES read strobes, one operate strobe, then an optional
// write strobe. Each strobe waits for its reply, bounded by a per-wait timeout.
module pulse_seq #(
  parameter int unsigned READ_PHASES = 2,
  parameter int unsigned TIMEOUT     = 64,
  parameter int unsigned TO_W        = 8,
  parameter int unsigned CNT_W       = 16
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             start_pulse,
  input  logic             stop_pulse,
  input  logic             continuous,
  input  logic             write_en,
  output logic             mem_read_pulse,
  output logic             mem_write_pulse,
  input  logic             mem_reply,
  output logic             operate_pulse,
  input  logic             operate_reply,
  output logic [1:0]       read_idx,
  output logic             busy,
  output logic             cycle_done,
  output logic             timeout_err,
  output logic [CNT_W-1:0] cycle_cnt
);

  typedef enum logic [3:0] {
    StIdle, StRdP, StRdW, StOpP, StOpW, StWrP, StWrW, StDone, StError
  } state_e;

  localparam logic [1:0]      LastIdx  = 2'(READ_PHASES - 1);
  localparam logic [TO_W-1:0] WaitLast = TO_W'(TIMEOUT - 1);

  state_e           state_q, state_d;
  logic [1:0]       idx_q, idx_d;
  logic [TO_W-1:0]  wait_q, wait_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             stop_req_q, stop_req_d;
  logic             expired;

  assign busy      = (state_q != StIdle) && (state_q != StError);
  assign read_idx  = idx_q;
  assign cycle_cnt = cnt_q;
  // Last permitted wait cycle; a reply seen in it still wins over the error.
  assign expired   = (wait_q == WaitLast);

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    wait_d     = '0;
    cnt_d      = cnt_q;
    stop_req_d = stop_req_q;
    if (busy && stop_pulse) stop_req_d = 1'b1;

    unique case (state_q)
      StIdle: begin
        if (start_pulse) begin
          state_d    = StRdP;
          idx_d      = '0;
          stop_req_d = stop_pulse;
        end
      end
      StRdP: state_d = StRdW;
      StRdW: begin
        if (mem_reply) begin
          if (idx_q != LastIdx) begin
            idx_d   = idx_q + 2'd1;
            state_d = StRdP;
          end else begin
            state_d = StOpP;
          end
        end else if (expired) begin
          state_d = StError;
        end else begin
          wait_d = wait_q + TO_W'(1);
        end
      end
      StOpP: state_d = StOpW;
      StOpW: begin
        if (operate_reply) begin
          state_d = write_en ? StWrP : StDone;
        end else if (expired) begin
          state_d = StError;
        end else begin
          wait_d = wait_q + TO_W'(1);
        end
      end
      StWrP: state_d = StWrW;
      StWrW: begin
        if (mem_reply) begin
          state_d = StDone;
        end else if (expired) begin
          state_d = StError;
        end else begin
          wait_d = wait_q + TO_W'(1);
        end
      end
      StDone: begin
        cnt_d = cnt_q + CNT_W'(1);
        // A stop arriving during DONE itself also ends the run here.
        if (continuous && !stop_req_q && !stop_pulse) begin
          state_d = StRdP;
          idx_d   = '0;
        end else begin
          state_d    = StIdle;
          stop_req_d = 1'b0;
        end
      end
      StError: begin
        if (stop_pulse) begin
          state_d    = StIdle;
          stop_req_d = 1'b0;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    mem_read_pulse  = 1'b0;
    mem_write_pulse = 1'b0;
    operate_pulse   = 1'b0;
    cycle_done      = 1'b0;
    timeout_err     = 1'b0;
    unique case (state_q)
      StRdP:   mem_read_pulse  = 1'b1;
      StOpP:   operate_pulse   = 1'b1;
      StWrP:   mem_write_pulse = 1'b1;
      StDone:  cycle_done      = 1'b1;
      StError: timeout_err     = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q    <= StIdle;
      idx_q      <= '0;
      wait_q     <= '0;
      cnt_q      <= '0;
      stop_req_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      wait_q     <= wait_d;
      cnt_q      <= cnt_d;
      stop_req_q <= stop_req_d;
    end
  end

endmodule

// File: tb/tb_pulse_seq.sv
`timescale 1ns/1ps
// Bench for pulse_seq: a procedural sequence model predicts every output each cycle; directed
// scenarios pin exact pulse timing, then randomized traffic runs against the same model.
module tb_pulse_seq;
  localparam int unsigned RP  = 2;
  localparam int unsigned TO  = 8;
  localparam int unsigned TOW = 4;
  localparam int unsigned CW  = 4;

  logic clk = 1'b0, resetn = 1'b0;
  logic start_pulse = 1'b0, stop_pulse = 1'b0, continuous = 1'b0, write_en = 1'b0;
  logic mem_reply, operate_reply;
  logic mem_read_pulse, mem_write_pulse, operate_pulse, busy, cycle_done, timeout_err;
  logic [1:0]    read_idx;
  logic [CW-1:0] cycle_cnt;

  logic mem_rsp = 1'b0, mem_force = 1'b0, op_rsp = 1'b0;
  bit   mem_drop = 1'b0;
  int   mem_dmin = 1, mem_dmax = 1, mem_wmax = 1, op_dmin = 1, op_dmax = 1, op_wmax = 1;
  assign mem_reply     = mem_rsp | mem_force;
  assign operate_reply = op_rsp;

  pulse_seq #(.READ_PHASES(RP), .TIMEOUT(TO), .TO_W(TOW), .CNT_W(CW)) dut (
    .clk(clk), .resetn(resetn), .start_pulse(start_pulse), .stop_pulse(stop_pulse),
    .continuous(continuous), .write_en(write_en), .mem_read_pulse(mem_read_pulse),
    .mem_write_pulse(mem_write_pulse), .mem_reply(mem_reply), .operate_pulse(operate_pulse),
    .operate_reply(operate_reply), .read_idx(read_idx), .busy(busy), .cycle_done(cycle_done),
    .timeout_err(timeout_err), .cycle_cnt(cycle_cnt)
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_fail = 0, cyc = 0, t0 = 0;
  int rd_n = 0, op_n = 0, wr_n = 0, done_n = 0;
  int rd_log[$], op_log[$], done_log[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic e_rd = 0, e_wr = 0, e_op = 0, e_busy = 0, e_done = 0, e_err = 0;
  logic [1:0]    e_idx = '0;
  logic [CW-1:0] e_cnt = '0;
  bit m_stop = 0;
  bit s_start, s_stop, s_cont, s_wen, s_mem, s_opr;

  // Advance one clock; inputs sampled belong to the cycle that just ended.
  task automatic m_tick(output bit rst_hit);
    @(posedge clk or negedge resetn);
    rst_hit = (resetn !== 1'b1);
    if (!rst_hit) begin
      s_start = start_pulse; s_stop = stop_pulse; s_cont = continuous;
      s_wen = write_en; s_mem = mem_reply; s_opr = operate_reply;
      if (s_stop && e_busy) m_stop = 1;
    end
  endtask

  task automatic m_strobe(input int kind, output bit rst_hit);
    e_busy = 1; e_done = 0;
    e_rd = (kind == 0); e_op = (kind == 1); e_wr = (kind == 2);
    m_tick(rst_hit);
    e_rd = 0; e_op = 0; e_wr = 0;
  endtask

  task automatic m_wait(input bit on_mem, output bit ok, output bit rst_hit);
    ok = 0; rst_hit = 0;
    for (int n = 0; n < int'(TO); n++) begin
      m_tick(rst_hit);
      if (rst_hit) return;
      if (on_mem ? s_mem : s_opr) begin ok = 1; return; end
    end
  endtask

  task automatic m_error(output bit rst_hit);
    e_busy = 0; e_err = 1;
    do begin
      m_tick(rst_hit);
      if (rst_hit) return;
    end while (!s_stop);
    e_err = 0; m_stop = 0;
  endtask

  task automatic m_run(output bit rst_hit);
    bit ok, more;
    e_busy = 0; e_done = 0; e_err = 0; e_rd = 0; e_op = 0; e_wr = 0;
    do begin
      m_tick(rst_hit);
      if (rst_hit) return;
    end while (!s_start);
    if (s_stop) m_stop = 1;
    more = 1;
    while (more) begin
      for (int i = 0; i < int'(RP); i++) begin
        e_idx = 2'(i);
        m_strobe(0, rst_hit); if (rst_hit) return;
        m_wait(1, ok, rst_hit); if (rst_hit) return;
        if (!ok) begin m_error(rst_hit); return; end
      end
      m_strobe(1, rst_hit); if (rst_hit) return;
      m_wait(0, ok, rst_hit); if (rst_hit) return;
      if (!ok) begin m_error(rst_hit); return; end
      if (s_wen) begin
        m_strobe(2, rst_hit); if (rst_hit) return;
        m_wait(1, ok, rst_hit); if (rst_hit) return;
        if (!ok) begin m_error(rst_hit); return; end
      end
      e_done = 1;
      m_tick(rst_hit); if (rst_hit) return;
      e_done = 0;
      e_cnt  = e_cnt + 1'b1;
      more   = s_cont && !m_stop;
      if (!more) m_stop = 0;
    end
  endtask

  initial begin : model
    bit r;
    forever begin
      e_rd = 0; e_wr = 0; e_op = 0; e_busy = 0; e_done = 0; e_err = 0;
      e_idx = '0; e_cnt = '0; m_stop = 0;
      wait (resetn === 1'b1);
      r = 0;
      while (!r) m_run(r);
    end
  end

  // ---------------- per-cycle compare and event log ----------------
  initial begin : monitor
    forever begin
      @(posedge clk);
      cyc++;
      #1;
      chk("mem_read_pulse", mem_read_pulse, e_rd);
      chk("mem_write_pulse", mem_write_pulse, e_wr);
      chk("operate_pulse", operate_pulse, e_op);
      chk("busy", busy, e_busy);
      chk("cycle_done", cycle_done, e_done);
      chk("timeout_err", timeout_err, e_err);
      chk("read_idx", read_idx, e_idx);
      chk("cycle_cnt", cycle_cnt, e_cnt);
      chk("strobe_onehot", $onehot0({mem_read_pulse, mem_write_pulse, operate_pulse}), 1);
      if (mem_read_pulse)  begin rd_n++; rd_log.push_back(cyc); end
      if (operate_pulse)   begin op_n++; op_log.push_back(cyc); end
      if (mem_write_pulse) wr_n++;
      if (cycle_done)      begin done_n++; done_log.push_back(cyc); end
    end
  end

  // ---------------- reply generators ----------------
  initial begin : mem_responder
    int d, w;
    @(negedge clk);
    forever begin
      if ((mem_read_pulse || mem_write_pulse) && !mem_drop) begin
        d = $urandom_range(mem_dmax, mem_dmin);
        w = $urandom_range(mem_wmax, 1);
        repeat (d) @(negedge clk);
        mem_rsp = 1;
        repeat (w) @(negedge clk);
        mem_rsp = 0;
      end else @(negedge clk);
    end
  end

  initial begin : op_responder
    int d, w;
    @(negedge clk);
    forever begin
      if (operate_pulse) begin
        d = $urandom_range(op_dmax, op_dmin);
        w = $urandom_range(op_wmax, 1);
        repeat (d) @(negedge clk);
        op_rsp = 1;
        repeat (w) @(negedge clk);
        op_rsp = 0;
      end else @(negedge clk);
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic pulse_start(input bit with_stop);
    @(negedge clk);
    start_pulse = 1; stop_pulse = with_stop; t0 = cyc;
    @(negedge clk);
    start_pulse = 0; stop_pulse = 0;
  endtask

  task automatic pulse_stop();
    @(negedge clk); stop_pulse = 1;
    @(negedge clk); stop_pulse = 0;
  endtask

  task automatic wait_idle(input string name, input int max);
    int n = 0;
    while (busy && n < max) begin @(negedge clk); n++; end
    chk({name, " idle"}, busy, 0);
  endtask

  function automatic int count_of(input int kind);
    case (kind)
      0: return rd_n;
      1: return op_n;
      2: return done_n;
      default: return wr_n;
    endcase
  endfunction

  task automatic wait_for(input string name, input int kind, input int target, input int max);
    int n = 0;
    while (count_of(kind) < target && n < max) begin @(negedge clk); n++; end
    chk({name, " reached"}, count_of(kind) >= target, 1);
  endtask

  task automatic do_reset();
    @(negedge clk); resetn = 0;
    @(negedge clk); @(negedge clk); resetn = 1;
  endtask

  task automatic cfg(input int md, input int od);
    mem_dmin = md; mem_dmax = md; mem_wmax = 1;
    op_dmin = od; op_dmax = od; op_wmax = 1;
  endtask

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: time limit reached before end of test");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    int b_rd, b_op, b_wr, b_dn;
    // Reset state
    repeat (2) @(negedge clk);
    chk("reset busy", busy, 0);
    chk("reset cnt", cycle_cnt, 0);
    chk("reset idx", read_idx, 0);
    chk("reset err", timeout_err, 0);
    chk("reset strobes", {mem_read_pulse, mem_write_pulse, operate_pulse, cycle_done}, 0);
    resetn = 1;

    // Single cycle, replies two cycles after each strobe
    cfg(2, 2); continuous = 0; write_en = 0;
    b_rd = rd_log.size(); b_op = op_log.size(); b_dn = done_log.size();
    pulse_start(0);
    wait_idle("t1", 40);
    chk("t1 read0 time", rd_log[b_rd], t0 + 1);
    chk("t1 read1 time", rd_log[b_rd + 1], t0 + 4);
    chk("t1 read count", rd_log.size() - b_rd, 2);
    chk("t1 op time", op_log[b_op], t0 + 7);
    chk("t1 done time", done_log[b_dn], t0 + 10);
    chk("t1 cnt", cycle_cnt, 1);

    // Continuous with write, stop during second operate wait
    cfg(1, 2); continuous = 1; write_en = 1;
    b_op = op_n; b_wr = wr_n; b_dn = done_n;
    pulse_start(0);
    wait_for("t2 op", 1, b_op + 2, 60);
    @(negedge clk);
    stop_pulse = 1;
    @(negedge clk);
    stop_pulse = 0;
    wait_idle("t2", 40);
    chk("t2 dones", done_n - b_dn, 2);
    chk("t2 writes", wr_n - b_wr, 2);
    chk("t2 cnt", cycle_cnt, 3);
    continuous = 0; write_en = 0;

    // Timeout on the first read
    cfg(1, 1); mem_drop = 1;
    b_rd = rd_n; b_op = op_n;
    pulse_start(0);
    while (cyc < t0 + 9) @(negedge clk);
    chk("t3 err before expiry", timeout_err, 0);
    chk("t3 busy before expiry", busy, 1);
    @(negedge clk);
    chk("t3 err", timeout_err, 1);
    chk("t3 busy", busy, 0);
    chk("t3 idx", read_idx, 0);
    pulse_start(0);
    repeat (12) @(negedge clk);
    chk("t3 err held", timeout_err, 1);
    chk("t3 no reads", rd_n - b_rd, 1);
    chk("t3 no ops", op_n - b_op, 0);
    mem_drop = 0;
    pulse_stop();
    chk("t3 cleared", timeout_err, 0);
    chk("t3 idle", busy, 0);

    // Reply held high across the read strobes
    cfg(1, 2);
    @(negedge clk); mem_force = 1;
    b_rd = rd_log.size(); b_dn = done_log.size();
    pulse_start(0);
    wait_idle("t4", 40);
    mem_force = 0;
    chk("t4 read count", rd_log.size() - b_rd, 2);
    chk("t4 read1 time", rd_log[b_rd + 1], t0 + 3);
    chk("t4 done time", done_log[b_dn], t0 + 8);

    // Asynchronous reset during operate wait
    cfg(1, 6);
    b_op = op_n;
    pulse_start(0);
    wait_for("t5 op", 1, b_op + 1, 40);
    @(negedge clk); @(negedge clk);
    #2 resetn = 0;
    #1;
    chk("t5 rst busy", busy, 0);
    chk("t5 rst strobes", {mem_read_pulse, mem_write_pulse, operate_pulse, cycle_done}, 0);
    chk("t5 rst err", timeout_err, 0);
    chk("t5 rst idx", read_idx, 0);
    chk("t5 rst cnt", cycle_cnt, 0);
    @(negedge clk); resetn = 1;
    cfg(1, 1);
    pulse_start(0);
    chk("t5 restart read", mem_read_pulse, 1);
    chk("t5 restart idx", read_idx, 0);
    wait_idle("t5", 40);
    chk("t5 cnt", cycle_cnt, 1);

    // Counter wrap after 17 cycles, then start+stop together
    do_reset();
    cfg(1, 1); continuous = 1;
    b_dn = done_n;
    pulse_start(0);
    wait_for("t6 dones", 2, b_dn + 16, 400);
    wait_for("t6 read", 0, rd_n + 1, 20);
    stop_pulse = 1;
    @(negedge clk);
    stop_pulse = 0;
    wait_idle("t6", 40);
    chk("t6 dones", done_n - b_dn, 17);
    chk("t6 cnt wrap", cycle_cnt, 1);
    b_dn = done_n;
    pulse_start(1);
    wait_idle("t6b", 40);
    repeat (10) @(negedge clk);
    chk("t6 start+stop dones", done_n - b_dn, 1);
    chk("t6 start+stop cnt", cycle_cnt, 2);
    continuous = 0;

    // Randomized traffic against the model
    mem_dmin = 1; mem_dmax = 3; mem_wmax = 2;
    op_dmin = 1; op_dmax = 3; op_wmax = 2;
    for (int i = 0; i < 4000; i++) begin
      @(negedge clk);
      start_pulse = ($urandom_range(9, 0) == 0);
      stop_pulse  = ($urandom_range(39, 0) == 0);
      write_en    = 1'($urandom_range(1, 0));
      if ($urandom_range(49, 0) == 0) continuous = ~continuous;
      mem_drop    = ($urandom_range(29, 0) == 0);
      resetn      = (i != 2000);
    end
    @(negedge clk);
    start_pulse = 0; stop_pulse = 0; continuous = 0; mem_drop = 0; resetn = 1;
    pulse_stop();
    wait_idle("random end", 100);
    repeat (4) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
